serdes_encrypt_scheduler: RTL and testbench

Front-end controller for `secure_serdes_encryptor_core`. It arbitrates round-robin among N_CH requesters, each offering an (A, B) byte pair, and drives the core's `start`/`a_bit`/`b_bit` pins MSB-first. It then deserialises the core's `cipher_out` stream and returns the byte, tagged with its channel. It also holds one 8-bit key per channel and presents the granted channel's key on the core key bus.

---
 rtl/serdes_pkg.sv | 24 ++
 rtl/serdes_encrypt_scheduler_rr_arbiter.sv | 46 ++++
 rtl/serdes_encrypt_scheduler.sv | 171 +++++++++++++++++
 tb/tb_serdes_encrypt_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and constants for the SERDES encryptor front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serdes_pkg;

  localparam int BYTE_W    = 8;
  localparam int FEED_LEN  = 8;
  localparam int WAIT_LEN  = 2;
  localparam int CAP_LEN   = 8;
  localparam int KEY_W     = 128;
  localparam int CH_W      = 2;
  // Key storage is sized for the widest legal channel count so a 2-bit index never runs off the end.
  localparam int KEY_SLOTS = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

endpackage

// File: rtl/serdes_encrypt_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Latency: grant is combinational from req/en; pointer moves on the accepting edge.
// Backpressure: no grant while en is low; pointer holds until a request is accepted.
module rr_arbiter
  import serdes_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            en,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx
);

  logic [CH_W-1:0] last_grant;

  // Scan from last_grant+1 upward, wrapping, and take the first requester found.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    found     = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_grant) + k) % N_CH;
      if (en && req[idx] && !found) begin
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
        found      = 1'b1;
      end
    end
  end

  // Remember the winner; any request while enabled is an accept since a grant is always issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= CH_W'(N_CH - 1);
    end else if (en && (|req)) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/serdes_encrypt_scheduler.sv
// Arbitrates N_CH byte-pair requesters onto the serial encryptor core and returns the tagged cipher byte.
// Latency: rsp_valid rises 19 cycles after the accepting edge; minimum issue interval 21 cycles.
// Backpressure: rsp_ready low holds the result in RESP; no requests are accepted until it is taken.
module serdes_encrypt_scheduler
  import serdes_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [BYTE_W*N_CH-1:0] req_a,
  input  logic [BYTE_W*N_CH-1:0] req_b,
  output logic [N_CH-1:0]        req_ready,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [BYTE_W-1:0]      cfg_key,
  output logic                   rsp_valid,
  output logic [CH_W-1:0]        rsp_ch,
  output logic [BYTE_W-1:0]      rsp_data,
  output logic                   rsp_err,
  input  logic                   rsp_ready,
  output logic                   core_start,
  output logic                   core_a_bit,
  output logic                   core_b_bit,
  output logic [KEY_W-1:0]       core_key,
  input  logic                   core_cipher,
  input  logic                   core_done
);

  state_t              state;
  logic [2:0]          cnt;
  logic [BYTE_W-1:0]   a_sh;
  logic [BYTE_W-1:0]   b_sh;
  logic [BYTE_W-2:0]   cap_sh;
  logic [CH_W-1:0]     ch_q;
  logic [BYTE_W-1:0]   key_q;
  logic [BYTE_W-1:0]   keys [KEY_SLOTS];
  logic [N_CH-1:0]     grant;
  logic [CH_W-1:0]     grant_idx;
  logic                arb_en;
  logic                accept;
  logic [BYTE_W-1:0]   sel_a;
  logic [BYTE_W-1:0]   sel_b;

  // Grants only in IDLE, and never while reset is held so req_ready reads 0 under reset.
  assign arb_en    = (state == IDLE) && !rst;
  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign core_key  = {{(KEY_W - BYTE_W){1'b0}}, key_q};

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pick the granted channel's byte pair out of the packed request buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_a = req_a[BYTE_W*i +: BYTE_W];
        sel_b = req_b[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // Per-channel key registers; writes to channels beyond N_CH are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KEY_SLOTS; i++) begin
        keys[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_ch) < N_CH)) begin
      keys[cfg_ch] <= cfg_key;
    end
  end

  // Transaction sequencer: grant, start pulse, MSB-first feed, core latency, capture, hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      cap_sh     <= '0;
      ch_q       <= '0;
      key_q      <= '0;
      core_start <= 1'b0;
      core_a_bit <= 1'b0;
      core_b_bit <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_ch     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh       <= sel_a;
            b_sh       <= sel_b;
            ch_q       <= grant_idx;
            // Non-blocking read: a same-edge key write is not seen by this grant.
            key_q      <= keys[grant_idx];
            core_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          core_start <= 1'b0;
          core_a_bit <= a_sh[BYTE_W-1];
          core_b_bit <= b_sh[BYTE_W-1];
          a_sh       <= a_sh << 1;
          b_sh       <= b_sh << 1;
          cnt        <= '0;
          state      <= FEED;
        end
        FEED: begin
          if (cnt == 3'(FEED_LEN - 1)) begin
            core_a_bit <= 1'b0;
            core_b_bit <= 1'b0;
            cnt        <= '0;
            state      <= WAIT;
          end else begin
            core_a_bit <= a_sh[BYTE_W-1];
            core_b_bit <= b_sh[BYTE_W-1];
            a_sh       <= a_sh << 1;
            b_sh       <= b_sh << 1;
            cnt        <= cnt + 3'd1;
          end
        end
        WAIT: begin
          if (cnt == 3'(WAIT_LEN - 1)) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CAPTURE: begin
          cap_sh <= {cap_sh[BYTE_W-3:0], core_cipher};
          if (cnt == 3'(CAP_LEN - 1)) begin
            rsp_data  <= {cap_sh, core_cipher};
            rsp_err   <= ~core_done;
            rsp_ch    <= ch_q;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_encrypt_scheduler.sv
// Self-checking bench: behavioural encryptor core (cipher = A ^ B ^ key[7:0]) plus a scoreboard.
// Stimulus pushes hand-computed expected responses; a negedge monitor pops and compares them.
// Covers reset, round-robin, backpressure, in-flight key writes, mid-capture reset and core fault.
module tb_serdes_encrypt_scheduler;

  localparam int N_CH = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_CH-1:0]     req_valid;
  logic [8*N_CH-1:0]   req_a;
  logic [8*N_CH-1:0]   req_b;
  logic [N_CH-1:0]     req_ready;
  logic                cfg_we;
  logic [1:0]          cfg_ch;
  logic [7:0]          cfg_key;
  logic                rsp_valid;
  logic [1:0]          rsp_ch;
  logic [7:0]          rsp_data;
  logic                rsp_err;
  logic                rsp_ready;
  logic                core_start;
  logic                core_a_bit;
  logic                core_b_bit;
  logic [127:0]        core_key;
  logic                core_cipher;
  logic                core_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       err;
    int         t_acc;
  } exp_t;

  exp_t exp_q[$];

  serdes_encrypt_scheduler #(.N_CH(N_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_key     (cfg_key),
    .rsp_valid   (rsp_valid),
    .rsp_ch      (rsp_ch),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rsp_ready   (rsp_ready),
    .core_start  (core_start),
    .core_a_bit  (core_a_bit),
    .core_b_bit  (core_b_bit),
    .core_key    (core_key),
    .core_cipher (core_cipher),
    .core_done   (core_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural core: start seen on edge T+1, bits sampled T+2..T+9, encrypt T+10,
  // cipher bits presented MSB-first from T+11 so they are sampled at T+12..T+19.
  int         ph;
  logic [7:0] ca, cb, cc;
  logic       fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; ca <= '0; cb <= '0; cc <= '0;
      core_cipher <= 1'b0; core_done <= 1'b0;
    end else if (core_start) begin
      ph <= 1;
    end else if (ph > 0) begin
      ph <= ph + 1;
      if (ph <= 8) begin
        ca <= {ca[6:0], core_a_bit};
        cb <= {cb[6:0], core_b_bit};
      end
      if (ph == 9) cc <= ca ^ cb ^ core_key[7:0];
      if (ph >= 10 && ph <= 17) core_cipher <= cc[17 - ph];
      if (ph == 17) core_done <= !fault;
      if (ph == 18) begin
        core_cipher <= 1'b0;
        core_done   <= 1'b0;
        ph          <= 0;
      end
    end
  end

  // Monitor: latency on the first valid cycle, payload on the handshake cycle.
  logic seen = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc - exp_q[0].t_acc), 32'd19);
        end
        if (rsp_ready) begin
          cur = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(cur.data));
          check("rsp_ch", 32'(rsp_ch), 32'(cur.ch));
          check("rsp_err", 32'(rsp_err), 32'(cur.err));
          seen = 1'b0;
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_ch"}, 32'(rsp_ch), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_core_bits"}, 32'({core_a_bit, core_b_bit}), 32'd0);
    check({tag, "_core_key_or"}, 32'(|core_key), 32'd0);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] key);
    cfg_ch  = ch;
    cfg_key = key;
    cfg_we  = 1'b1;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
  endtask

  // Offer one pair, wait (bounded) for its grant, record the expectation, then withdraw.
  task automatic send(input int ch, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e, input logic err);
    int w;
    w = 0;
    req_a[8*ch +: 8] = a;
    req_b[8*ch +: 8] = b;
    req_valid[ch]    = 1'b1;
    @(negedge clk);
    while (!req_ready[ch] && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("grant_wait_bound", 32'(w < 200), 32'd1);
    check("grant_onehot", 32'(req_ready), 32'(1 << ch));
    exp_q.push_back('{ch: 2'(ch), data: e, err: err, t_acc: cyc + 1});
    @(posedge clk);
    #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_bound", 32'(w < 300), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_a [2][2] = '{'{8'h11, 8'h5A}, '{8'h12, 8'h80}};
  logic [7:0] rr_b [2][2] = '{'{8'h22, 8'h0F}, '{8'h34, 8'h01}};
  logic [7:0] rr_e [2][2] = '{'{8'h33, 8'h55}, '{8'hD9, 8'h7E}};
  int         rr_order [4] = '{0, 1, 0, 1};

  initial begin
    int sent [2];
    int w;
    int g;

    rst = 1'b1;
    req_a = '0; req_b = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_key = '0;
    rsp_ready = 1'b1;
    fault = 1'b0;
    // Requests held during reset must not be granted.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    // Round-robin with both channels continuously valid; key0=0x00, key1=0xFF.
    cfg_write(2'd1, 8'hFF);
    sent[0] = 0;
    sent[1] = 0;
    for (int c = 0; c < 2; c++) begin
      req_a[8*c +: 8] = rr_a[c][0];
      req_b[8*c +: 8] = rr_b[c][0];
    end
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      w = 0;
      @(negedge clk);
      while (req_ready == '0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("rr_wait_bound", 32'(w < 100), 32'd1);
      check("rr_grant", 32'(req_ready), 32'(1 << rr_order[n]));
      g = req_ready[1] ? 1 : 0;
      exp_q.push_back('{ch: 2'(g), data: rr_e[g][sent[g]], err: 1'b0, t_acc: cyc + 1});
      @(posedge clk);
      #1;
      sent[g]++;
      if (sent[g] == 2) begin
        req_valid[g] = 1'b0;
      end else begin
        req_a[8*g +: 8] = rr_a[g][sent[g]];
        req_b[8*g +: 8] = rr_b[g][sent[g]];
      end
    end
    drain();

    // Single transaction: key0=0x0F, 0x3C ^ 0xA5 ^ 0x0F = 0x96.
    cfg_write(2'd0, 8'h0F);
    send(0, 8'h3C, 8'hA5, 8'h96, 1'b0);
    drain();

    // Backpressure: ch1 0x12 ^ 0x34 ^ 0xFF = 0xD9 held for 50 cycles while ch0 waits.
    rsp_ready = 1'b0;
    send(1, 8'h12, 8'h34, 8'hD9, 1'b0);
    w = 0;
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_valid_bound", 32'(w < 100), 32'd1);
    req_a[7:0] = 8'h00;
    req_b[7:0] = 8'h00;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'hD9);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after_release", 32'(req_ready), 32'b01);
    exp_q.push_back('{ch: 2'd0, data: 8'h0F, err: 1'b0, t_acc: cyc + 1});
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    drain();

    // Key write during FEED: in-flight uses 0x0F (-> 0xF0), next uses 0xFF (-> 0x00).
    send(0, 8'hF0, 8'h0F, 8'hF0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cfg_write(2'd0, 8'hFF);
    drain();
    send(0, 8'hF0, 8'h0F, 8'h00, 1'b0);
    drain();

    // Reset during CAPTURE: nothing returned; ch0 wins first afterwards with cleared keys.
    send(0, 8'h01, 8'h02, 8'h03, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    req_a = {8'h12, 8'h3C};
    req_b = {8'h34, 8'hA5};
    req_valid = 2'b11;
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_grant", 32'(req_ready), 32'b01);
    exp_q.push_back('{ch: 2'd0, data: 8'h99, err: 1'b0, t_acc: cyc + 1});
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Core fault: done never asserted; data still 0x55 ^ 0xAA ^ 0x00 = 0xFF.
    fault = 1'b1;
    send(1, 8'h55, 8'hAA, 8'hFF, 1'b1);
    drain();
    fault = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
